// File: rtl/seqmult_pkg.sv
// Shared definitions for the sequential shift-add multiplier.
package seqmult_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/seqmult_pipe_hs.sv
// Sequential shift-add multiplier with load/ready and valid/ready handshakes.
// Operands are captured as magnitudes; the sign is reapplied once at the end,
// so the most negative operand value is handled exactly.
module seqmult_pipe_hs
  import seqmult_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter int SIGNED_EN = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 load,
  input  logic [WIDTH-1:0]     in_a,
  input  logic [WIDTH-1:0]     in_b,
  input  logic                 in_signed,
  output logic                 ready,
  output logic                 out_valid,
  output logic [2*WIDTH-1:0]   out_prod,
  input  logic                 out_ready
);

  localparam int CW = $clog2(WIDTH + 1);

  state_t               r_state;
  state_t               w_state_next;
  logic [2*WIDTH-1:0]   r_mcand;     // multiplicand magnitude, shifted left per bit
  logic [WIDTH-1:0]     r_mplier;    // multiplier magnitude, shifted right per bit
  logic [2*WIDTH-1:0]   r_acc;
  logic [CW-1:0]        r_cnt;
  logic                 r_sign;
  logic [2*WIDTH-1:0]   r_prod;

  logic                 w_signed_mode;
  logic                 w_a_neg;
  logic                 w_b_neg;
  logic [WIDTH-1:0]     w_a_mag;
  logic [WIDTH-1:0]     w_b_mag;
  logic                 w_accept;
  logic                 w_calc_last;

  // Magnitude extraction; -2^(WIDTH-1) negates to itself, which is its correct unsigned magnitude.
  assign w_signed_mode = (SIGNED_EN != 0) && in_signed;
  assign w_a_neg       = w_signed_mode && in_a[WIDTH-1];
  assign w_b_neg       = w_signed_mode && in_b[WIDTH-1];
  assign w_a_mag       = w_a_neg ? (~in_a + 1'b1) : in_a;
  assign w_b_mag       = w_b_neg ? (~in_b + 1'b1) : in_b;
  assign w_accept      = (r_state == IDLE) && load;
  assign w_calc_last   = (r_state == CALC) && (r_cnt == CW'(WIDTH));

  // State register.
  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_next;
  end

  // Next-state logic: one extra CALC cycle after the last bit latches the signed result.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (load)        w_state_next = CALC;
      CALC:    if (w_calc_last) w_state_next = DONE;
      DONE:    if (out_ready)   w_state_next = IDLE;
      default:                  w_state_next = IDLE;
    endcase
  end

  // Handshake outputs decoded from state.
  always_comb begin
    ready     = 1'b0;
    out_valid = 1'b0;
    case (r_state)
      IDLE:    ready     = 1'b1;
      DONE:    out_valid = 1'b1;
      default: ;
    endcase
  end

  // Datapath: capture, one multiplier bit per CALC cycle, final sign fix-up into r_prod.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_sign   <= 1'b0;
      r_prod   <= '0;
    end else if (w_accept) begin
      r_mcand  <= {{WIDTH{1'b0}}, w_a_mag};
      r_mplier <= w_b_mag;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_sign   <= w_a_neg ^ w_b_neg;
    end else if (r_state == CALC) begin
      if (w_calc_last) begin
        r_prod <= r_sign ? (~r_acc + 1'b1) : r_acc;
      end else begin
        if (r_mplier[0]) r_acc <= r_acc + r_mcand;
        r_mcand  <= r_mcand << 1;
        r_mplier <= r_mplier >> 1;
        r_cnt    <= r_cnt + 1'b1;
      end
    end
  end

  assign out_prod = r_prod;

endmodule

// File: tb/tb_seqmult_pipe_hs.sv
// Directed bench for seqmult_pipe_hs (WIDTH=8, SIGNED_EN=1).
module tb_seqmult_pipe_hs;

  localparam int W = 8;

  logic           clk = 1'b0;
  logic           reset;
  logic           load;
  logic [W-1:0]   in_a;
  logic [W-1:0]   in_b;
  logic           in_signed;
  logic           ready;
  logic           out_valid;
  logic [2*W-1:0] out_prod;
  logic           out_ready;

  int checks = 0;
  int errors = 0;

  seqmult_pipe_hs #(.WIDTH(W), .SIGNED_EN(1)) dut (
    .clk       (clk),
    .reset     (reset),
    .load      (load),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_signed (in_signed),
    .ready     (ready),
    .out_valid (out_valid),
    .out_prod  (out_prod),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one operation, wait for the result, check latency and product, then consume it.
  task automatic run_op(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic s, input logic [2*W-1:0] exp_prod);
    int n;
    checks++;
    if (ready !== 1'b1) begin
      errors++;
      $display("FAIL %s ready_before_load: got %b want 1", name, ready);
    end
    in_a = a; in_b = b; in_signed = s; load = 1'b1;
    tick();
    load = 1'b0;
    checks++;
    if (ready !== 1'b0) begin
      errors++;
      $display("FAIL %s ready_after_load: got %b want 0", name, ready);
    end
    n = 0;
    while (out_valid !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    checks++;
    if (n !== W + 1) begin
      errors++;
      $display("FAIL %s latency: got %0d want %0d", name, n, W + 1);
    end
    checks++;
    if (out_prod !== exp_prod) begin
      errors++;
      $display("FAIL %s product: got %h want %h", name, out_prod, exp_prod);
    end
    $display("op %s: a=%h b=%h signed=%b prod=%h latency=%0d", name, a, b, s, out_prod, n);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || ready !== 1'b1) begin
      errors++;
      $display("FAIL %s consume: got valid=%b ready=%b want valid=0 ready=1", name, out_valid, ready);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; load = 1'b1; in_a = 8'h05; in_b = 8'h05; in_signed = 1'b0; out_ready = 1'b0;
    tick();
    tick();
    reset = 1'b0; load = 1'b0;
    checks++;
    if (ready !== 1'b1 || out_valid !== 1'b0 || out_prod !== 16'h0000) begin
      errors++;
      $display("FAIL reset_state: got ready=%b valid=%b prod=%h want 1 0 0000", ready, out_valid, out_prod);
    end
    tick();
    tick();
    checks++;
    if (ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_load_ignored: got ready=%b want 1", ready);
    end
    $display("reset: ready=%b valid=%b prod=%h", ready, out_valid, out_prod);
  endtask

  task automatic test_unsigned();
    run_op("u13x11",  8'd13,  8'd11, 1'b0, 16'h008F);
    run_op("u255x255", 8'hFF, 8'hFF, 1'b0, 16'hFE01);
    run_op("uFDx05",  8'hFD,  8'h05, 1'b0, 16'h04F1);
    run_op("u0x9A",   8'h00,  8'h9A, 1'b0, 16'h0000);
  endtask

  task automatic test_signed();
    run_op("sm3x5",     8'hFD, 8'h05, 1'b1, 16'hFFF1);
    run_op("sm128xm128", 8'h80, 8'h80, 1'b1, 16'h4000);
    run_op("sm128x127", 8'h80, 8'h7F, 1'b1, 16'hC080);
    run_op("s7xm1",     8'h07, 8'hFF, 1'b1, 16'hFFF9);
  endtask

  task automatic test_hold();
    int n;
    int bad;
    in_a = 8'd2; in_b = 8'd3; in_signed = 1'b0; load = 1'b1;
    tick();
    load = 1'b0;
    n = 0;
    while (out_valid !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    checks++;
    if (out_valid !== 1'b1) begin
      errors++;
      $display("FAIL hold_valid_timeout: got valid=%b want 1", out_valid);
    end
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      load = i[0]; in_a = 8'(i * 7 + 1); in_b = 8'(i + 3);
      tick();
      checks++;
      if (out_valid !== 1'b1 || ready !== 1'b0 || out_prod !== 16'h0006) begin
        errors++;
        bad++;
        $display("FAIL hold_cycle%0d: got valid=%b ready=%b prod=%h want 1 0 0006",
                 i, out_valid, ready, out_prod);
      end
    end
    $display("hold: 20 stall cycles, %0d bad, prod=%h", bad, out_prod);
    load = 1'b1; out_ready = 1'b1; in_a = 8'd9; in_b = 8'd9;
    tick();
    load = 1'b0; out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || ready !== 1'b1) begin
      errors++;
      $display("FAIL hold_release: got valid=%b ready=%b want 0 1", out_valid, ready);
    end
    tick();
    checks++;
    if (ready !== 1'b1 || out_prod !== 16'h0006) begin
      errors++;
      $display("FAIL hold_load_on_accept_ignored: got ready=%b prod=%h want 1 0006", ready, out_prod);
    end
  endtask

  task automatic test_input_change();
    int n;
    in_a = 8'h0C; in_b = 8'h0A; in_signed = 1'b0; load = 1'b1;
    tick();
    load = 1'b0;
    n = 0;
    while (out_valid !== 1'b1 && n < 50) begin
      in_a = 8'($urandom); in_b = 8'($urandom); in_signed = 1'($urandom);
      tick();
      n++;
    end
    checks++;
    if (out_prod !== 16'h0078 || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL input_change: got valid=%b prod=%h want 1 0078", out_valid, out_prod);
    end
    $display("input_change: prod=%h", out_prod);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    in_a = 8'd5; in_b = 8'd5; in_signed = 1'b0; load = 1'b1;
    tick();
    load = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++;
    if (ready !== 1'b1 || out_valid !== 1'b0 || out_prod !== 16'h0000) begin
      errors++;
      $display("FAIL reset_mid: got ready=%b valid=%b prod=%h want 1 0 0000", ready, out_valid, out_prod);
    end
    $display("reset_mid: ready=%b valid=%b prod=%h", ready, out_valid, out_prod);
    run_op("after_reset7x9", 8'd7, 8'd9, 1'b0, 16'h003F);
  endtask

  // With both handshakes held high, each result occupies WIDTH+1 cycles to compute,
  // one DONE cycle and one IDLE cycle before the next load is taken.
  task automatic test_back_to_back();
    int hits[$];
    in_a = 8'd3; in_b = 8'd4; in_signed = 1'b0;
    load = 1'b1; out_ready = 1'b1;
    for (int c = 0; c < 45; c++) begin
      tick();
      if (out_valid === 1'b1) begin
        hits.push_back(c);
        checks++;
        if (out_prod !== 16'h000C) begin
          errors++;
          $display("FAIL b2b_prod: got %h want 000C", out_prod);
        end
        $display("b2b: result at cycle %0d prod=%h", c, out_prod);
      end
    end
    load = 1'b0; out_ready = 1'b0;
    checks++;
    if (hits.size() < 3) begin
      errors++;
      $display("FAIL b2b_count: got %0d want >=3", hits.size());
    end else begin
      for (int k = 1; k < hits.size(); k++) begin
        checks++;
        if (hits[k] - hits[k-1] !== W + 3) begin
          errors++;
          $display("FAIL b2b_period: got %0d want %0d", hits[k] - hits[k-1], W + 3);
        end
      end
    end
    tick();
    tick();
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_hold();
    test_input_change();
    test_reset_mid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
